// File: rtl/aes_intr_pkg.sv
// Shared register-map constants, response codes and decode helpers for the
// AES interrupt register block.
package aes_intr_pkg;

   localparam logic [7:0] OFF_GIE = 8'h00;
   localparam logic [7:0] OFF_IER = 8'h04;
   localparam logic [7:0] OFF_ISR = 8'h08;
   localparam logic [7:0] OFF_IAR = 8'h0C;
   localparam logic [7:0] OFF_IPR = 8'h10;

   typedef logic [2:0] reg_idx_t;

   localparam reg_idx_t IDX_GIE  = 3'd0;
   localparam reg_idx_t IDX_IER  = 3'd1;
   localparam reg_idx_t IDX_ISR  = 3'd2;
   localparam reg_idx_t IDX_IAR  = 3'd3;
   localparam reg_idx_t IDX_IPR  = 3'd4;
   localparam reg_idx_t IDX_NONE = 3'd7;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   // Any address bit above the 0x1C window marks the access as unmapped.
   function automatic reg_idx_t decode(input logic [31:0] addr);
      reg_idx_t idx;
      if (addr[31:5] != 27'd0) begin
         idx = IDX_NONE;
      end else begin
         case (addr[4:2])
            OFF_GIE[4:2]: idx = IDX_GIE;
            OFF_IER[4:2]: idx = IDX_IER;
            OFF_ISR[4:2]: idx = IDX_ISR;
            OFF_IAR[4:2]: idx = IDX_IAR;
            OFF_IPR[4:2]: idx = IDX_IPR;
            default:      idx = IDX_NONE;
         endcase
      end
      return idx;
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/aes_intr_detect.sv
// Per-source event detector: level compare or active-going edge against the
// previous sample, with configurable polarity.
module aes_intr_detect #(
   parameter bit SENS   = 1'b1,
   parameter bit ACTIVE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic src,
   output logic det
);

   logic src_d;

   // Reset to the inactive level so no edge is seen right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_d <= ~ACTIVE;
      end else begin
         src_d <= src;
      end
   end

   always_comb begin
      det = 1'b0;
      if (SENS) begin
         det = (src == ACTIVE) && (src_d != ACTIVE);
      end else begin
         det = (src == ACTIVE);
      end
   end

endmodule

// File: rtl/aes_axil_intr_responder.sv
// AXI4-Lite interrupt register block: GIE/IER/ISR/IAR/IPR with level or
// pulse irq generation.
module aes_axil_intr_responder
   import aes_intr_pkg::*;
#(
   parameter int          C_NUM_OF_INTR      = 1,
   parameter int          C_ADDR_WIDTH       = 5,
   parameter int          C_DATA_WIDTH       = 32,
   parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFF_FFFF,
   parameter logic [31:0] C_INTR_ACTIVE      = 32'hFFFF_FFFF,
   parameter int          C_IRQ_SENSITIVITY  = 1,
   parameter bit          C_IRQ_ACTIVE_STATE = 1'b1,
   parameter int          C_IRQ_PULSE_LEN    = 2
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic [C_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                  s_axi_awprot,
   input  logic                        s_axi_awvalid,
   output logic                        s_axi_awready,
   input  logic [C_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                        s_axi_wvalid,
   output logic                        s_axi_wready,
   output logic [1:0]                  s_axi_bresp,
   output logic                        s_axi_bvalid,
   input  logic                        s_axi_bready,
   input  logic [C_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                  s_axi_arprot,
   input  logic                        s_axi_arvalid,
   output logic                        s_axi_arready,
   output logic [C_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rvalid,
   input  logic                        s_axi_rready,
   input  logic [C_NUM_OF_INTR-1:0]    intr_src,
   output logic                        irq
);

   localparam int N  = C_NUM_OF_INTR;
   localparam int CW = $clog2(C_IRQ_PULSE_LEN + 1);

   typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ACK = 2'd1, WR_RESP = 2'd2} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ACK = 2'd1, RD_RESP = 2'd2} rd_state_t;

   wr_state_t         wr_state, wr_state_nxt;
   rd_state_t         rd_state, rd_state_nxt;
   reg_idx_t          wr_idx, rd_idx;
   logic              wr_commit, rd_commit;
   logic [31:0]       wmask, rd_mux, rdata;
   logic              gie;
   logic [N-1:0]      ier, isr, ipr, det, ack;
   logic              irq_cond, irq_cond_d, irq_r;
   logic [CW-1:0]     pulse_cnt;
   logic              unused_bits;

   assign wr_idx    = decode(32'(s_axi_awaddr));
   assign rd_idx    = decode(32'(s_axi_araddr));
   assign wmask     = strb_mask(s_axi_wstrb);
   assign wr_commit = (wr_state == WR_ACK) && s_axi_awvalid && s_axi_wvalid;
   assign rd_commit = (rd_state == RD_ACK) && s_axi_arvalid;
   assign ipr       = isr & ier;
   assign irq_cond  = gie && (|ipr);
   assign ack       = (wr_commit && wr_idx == IDX_IAR) ? (s_axi_wdata[N-1:0] & wmask[N-1:0]) : '0;

   assign s_axi_awready = (wr_state == WR_ACK);
   assign s_axi_wready  = (wr_state == WR_ACK);
   assign s_axi_bvalid  = (wr_state == WR_RESP);
   assign s_axi_bresp   = 2'(RESP_OKAY);
   assign s_axi_arready = (rd_state == RD_ACK);
   assign s_axi_rvalid  = (rd_state == RD_RESP);
   assign s_axi_rresp   = 2'(RESP_OKAY);
   assign s_axi_rdata   = rdata;
   assign irq           = irq_r;
   assign unused_bits   = ^{s_axi_awprot, s_axi_arprot, s_axi_wdata, wmask};

   for (genvar g = 0; g < N; g++) begin : g_det
      aes_intr_detect #(
         .SENS   (C_INTR_SENSITIVITY[g]),
         .ACTIVE (C_INTR_ACTIVE[g])
      ) u_det (
         .clk (ACLK),
         .rst (ARESET),
         .src (intr_src[g]),
         .det (det[g])
      );
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
      end else begin
         wr_state <= wr_state_nxt;
         rd_state <= rd_state_nxt;
      end
   end

   // Ready is raised for exactly one cycle; a master that drops valid then is simply ignored.
   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         WR_IDLE: if (s_axi_awvalid && s_axi_wvalid) wr_state_nxt = WR_ACK;  else wr_state_nxt = WR_IDLE;
         WR_ACK:  if (wr_commit)                     wr_state_nxt = WR_RESP; else wr_state_nxt = WR_IDLE;
         WR_RESP: if (s_axi_bready)                  wr_state_nxt = WR_IDLE; else wr_state_nxt = WR_RESP;
         default: wr_state_nxt = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE: if (s_axi_arvalid) rd_state_nxt = RD_ACK;  else rd_state_nxt = RD_IDLE;
         RD_ACK:  if (rd_commit)     rd_state_nxt = RD_RESP; else rd_state_nxt = RD_IDLE;
         RD_RESP: if (s_axi_rready)  rd_state_nxt = RD_IDLE; else rd_state_nxt = RD_RESP;
         default: rd_state_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (rd_idx)
         IDX_GIE: rd_mux[0]     = gie;
         IDX_IER: rd_mux[N-1:0] = ier;
         IDX_ISR: rd_mux[N-1:0] = isr;
         IDX_IPR: rd_mux[N-1:0] = ipr;
         default: rd_mux        = '0;
      endcase
   end

   // Detection is ORed after the ack clear so a same-cycle event is never lost.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         gie   <= 1'b0;
         ier   <= '0;
         isr   <= '0;
         rdata <= '0;
      end else begin
         if (wr_commit && wr_idx == IDX_GIE && wmask[0]) begin
            gie <= s_axi_wdata[0];
         end
         if (wr_commit && wr_idx == IDX_IER) begin
            ier <= (ier & ~wmask[N-1:0]) | (s_axi_wdata[N-1:0] & wmask[N-1:0]);
         end
         isr <= det | (isr & ~ack);
         if (rd_commit) begin
            rdata <= rd_mux;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         irq_r      <= ~C_IRQ_ACTIVE_STATE;
         irq_cond_d <= 1'b0;
         pulse_cnt  <= '0;
      end else begin
         irq_cond_d <= irq_cond;
         if (C_IRQ_SENSITIVITY != 0) begin
            irq_r <= irq_cond ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
         end else if (irq_cond && !irq_cond_d && pulse_cnt == '0) begin
            irq_r     <= C_IRQ_ACTIVE_STATE;
            pulse_cnt <= CW'(C_IRQ_PULSE_LEN - 1);
         end else if (pulse_cnt != '0) begin
            irq_r     <= C_IRQ_ACTIVE_STATE;
            pulse_cnt <= pulse_cnt - CW'(1);
         end else begin
            irq_r <= ~C_IRQ_ACTIVE_STATE;
         end
      end
   end

endmodule

// File: tb/tb_aes_axil_intr_responder.sv
// Bench for the AES interrupt register block: a level-irq and a pulse-irq
// instance share all inputs and are checked against a cycle model.
module tb_aes_axil_intr_responder;

   localparam int         N    = 4;
   localparam logic [3:0] SENS = 4'b0011;
   localparam logic [3:0] ACT  = 4'b0101;
   localparam logic [3:0] IDLE_SRC = ~ACT;
   localparam int         PLEN = 2;

   logic        aclk = 1'b0;
   logic        areset;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [N-1:0] intr_src;

   logic        awready_l, wready_l, bvalid_l, arready_l, rvalid_l, irq_l;
   logic [1:0]  bresp_l, rresp_l;
   logic [31:0] rdata_l;
   logic        unused_awready_p, unused_wready_p, bvalid_p, unused_arready_p, rvalid_p, irq_p;
   logic [1:0]  unused_bresp_p, unused_rresp_p;
   logic [31:0] rdata_p;

   int n_vec = 0;
   int n_err = 0;

   // Cycle model state
   logic        m_gie;
   logic [3:0]  m_ier, m_isr, m_src_prev;
   logic        m_irq_l, m_irq_p, m_prev_cond;
   int          m_rem;
   bit          c_wr;
   logic [4:0]  c_addr;
   logic [31:0] c_data;
   logic [3:0]  c_strb;

   always #5 aclk = ~aclk;

   aes_axil_intr_responder #(
      .C_NUM_OF_INTR(N), .C_ADDR_WIDTH(5), .C_DATA_WIDTH(32),
      .C_INTR_SENSITIVITY(32'h0000_0003), .C_INTR_ACTIVE(32'h0000_0005),
      .C_IRQ_SENSITIVITY(1), .C_IRQ_ACTIVE_STATE(1'b1), .C_IRQ_PULSE_LEN(PLEN)
   ) dut_l (
      .ACLK(aclk), .ARESET(areset),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready_l),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready_l),
      .s_axi_bresp(bresp_l), .s_axi_bvalid(bvalid_l), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready_l),
      .s_axi_rdata(rdata_l), .s_axi_rresp(rresp_l), .s_axi_rvalid(rvalid_l), .s_axi_rready(rready),
      .intr_src(intr_src), .irq(irq_l)
   );

   aes_axil_intr_responder #(
      .C_NUM_OF_INTR(N), .C_ADDR_WIDTH(5), .C_DATA_WIDTH(32),
      .C_INTR_SENSITIVITY(32'h0000_0003), .C_INTR_ACTIVE(32'h0000_0005),
      .C_IRQ_SENSITIVITY(0), .C_IRQ_ACTIVE_STATE(1'b1), .C_IRQ_PULSE_LEN(PLEN)
   ) dut_p (
      .ACLK(aclk), .ARESET(areset),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(unused_awready_p),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(unused_wready_p),
      .s_axi_bresp(unused_bresp_p), .s_axi_bvalid(bvalid_p), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(unused_arready_p),
      .s_axi_rdata(rdata_p), .s_axi_rresp(unused_rresp_p), .s_axi_rvalid(rvalid_p), .s_axi_rready(rready),
      .intr_src(intr_src), .irq(irq_p)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] bmask(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
      return m;
   endfunction

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      case (a)
         5'h00:   return {31'd0, m_gie};
         5'h04:   return {28'd0, m_ier};
         5'h08:   return {28'd0, m_isr};
         5'h10:   return {28'd0, m_isr & m_ier};
         default: return 32'd0;
      endcase
   endfunction

   // One clock: evaluate the model from pre-edge state, advance, check irq outputs.
   task automatic step();
      logic [3:0] det, ack, m;
      logic       cond, n_gie, n_irq_p;
      logic [3:0] n_ier, n_isr;
      int         n_rem;
      for (int i = 0; i < N; i++) begin
         if (SENS[i]) det[i] = (intr_src[i] == ACT[i]) && (m_src_prev[i] != ACT[i]);
         else         det[i] = (intr_src[i] == ACT[i]);
      end
      m     = bmask(c_strb)[3:0];
      ack   = 4'd0;
      n_gie = m_gie;
      n_ier = m_ier;
      if (c_wr) begin
         if (c_addr == 5'h00 && c_strb[0]) n_gie = c_data[0];
         if (c_addr == 5'h04) n_ier = (m_ier & ~m) | (c_data[3:0] & m);
         if (c_addr == 5'h0C) ack = c_data[3:0] & m;
      end
      cond  = m_gie && ((m_isr & m_ier) != 4'd0);
      n_isr = det | (m_isr & ~ack);
      n_rem = m_rem;
      if (cond && !m_prev_cond && m_rem == 0) n_rem = PLEN;
      n_irq_p = (n_rem > 0);
      if (n_rem > 0) n_rem--;
      @(posedge aclk);
      if (areset) begin
         m_gie = 1'b0; m_ier = 4'd0; m_isr = 4'd0; m_src_prev = IDLE_SRC;
         m_irq_l = 1'b0; m_irq_p = 1'b0; m_prev_cond = 1'b0; m_rem = 0;
      end else begin
         m_gie = n_gie; m_ier = n_ier; m_isr = n_isr; m_src_prev = intr_src;
         m_irq_l = cond; m_irq_p = n_irq_p; m_prev_cond = cond; m_rem = n_rem;
      end
      c_wr = 1'b0;
      @(negedge aclk);
      chk("irq_level", {31'd0, irq_l}, {31'd0, m_irq_l});
      chk("irq_pulse", {31'd0, irq_p}, {31'd0, m_irq_p});
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit use_src, input logic [3:0] src_c);
      bit got = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         if (awready_l && wready_l) begin
            got = 1;
            c_wr = 1'b1; c_addr = a; c_data = d; c_strb = s;
            if (use_src) intr_src = src_c;
         end
         step();
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!got) chk("aw_w_handshake_timeout", 32'd0, 32'd1);
      chk("bvalid_after_hs", {31'd0, bvalid_l}, 32'd1);
      chk("bvalid_p_after_hs", {31'd0, bvalid_p}, 32'd1);
      chk("awready_one_cycle", {31'd0, awready_l}, 32'd0);
      chk("bresp", {30'd0, bresp_l}, 32'd0);
      bready = 1'b1;
      step();
      bready = 1'b0;
      chk("bvalid_cleared", {31'd0, bvalid_l}, 32'd0);
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] data, output logic [31:0] mexp);
      bit got = 0;
      mexp = 32'd0;
      araddr = a; arvalid = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         if (arready_l) begin
            got = 1;
            mexp = model_rd(a);
         end
         step();
      end
      arvalid = 1'b0;
      if (!got) chk("ar_handshake_timeout", 32'd0, 32'd1);
      chk("rvalid_after_hs", {31'd0, rvalid_l}, 32'd1);
      chk("rresp", {30'd0, rresp_l}, 32'd0);
      chk("rdata_pulse_inst", rdata_p, mexp);
      data = rdata_l;
      rready = 1'b1;
      step();
      rready = 1'b0;
      chk("rvalid_cleared", {31'd0, rvalid_l}, 32'd0);
   endtask

   typedef struct {
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [4:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] rd, mx;
      int cnt;
      bit got;

      tbl[0]  = '{5'h00, 32'h0000_0001, 4'hF, 5'h00, 32'h0000_0001};
      tbl[1]  = '{5'h04, 32'h0000_0001, 4'hF, 5'h04, 32'h0000_0001};
      tbl[2]  = '{5'h04, 32'h0000_000F, 4'hF, 5'h04, 32'h0000_000F};
      tbl[3]  = '{5'h04, 32'h0000_0000, 4'h0, 5'h04, 32'h0000_000F};
      tbl[4]  = '{5'h04, 32'hFFFF_FFF5, 4'h1, 5'h04, 32'h0000_0005};
      tbl[5]  = '{5'h04, 32'h0000_000A, 4'h2, 5'h04, 32'h0000_0005};
      tbl[6]  = '{5'h14, 32'hFFFF_FFFF, 4'hF, 5'h14, 32'h0000_0000};
      tbl[7]  = '{5'h0C, 32'h0000_0000, 4'hF, 5'h0C, 32'h0000_0000};
      tbl[8]  = '{5'h08, 32'h0000_000F, 4'hF, 5'h08, 32'h0000_0000};
      tbl[9]  = '{5'h00, 32'hFFFF_FFFE, 4'hF, 5'h00, 32'h0000_0000};
      tbl[10] = '{5'h00, 32'h0000_0001, 4'hF, 5'h1C, 32'h0000_0000};
      tbl[11] = '{5'h04, 32'h0000_0001, 4'hF, 5'h04, 32'h0000_0001};

      areset = 1'b1; awaddr = 5'd0; araddr = 5'd0; awprot = 3'd0; arprot = 3'd0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = 32'd0; wstrb = 4'd0; intr_src = IDLE_SRC;
      c_wr = 1'b0; c_addr = 5'd0; c_data = 32'd0; c_strb = 4'd0;
      m_gie = 1'b0; m_ier = 4'd0; m_isr = 4'd0; m_src_prev = IDLE_SRC;
      m_irq_l = 1'b0; m_irq_p = 1'b0; m_prev_cond = 1'b0; m_rem = 0;

      step(); step();
      areset = 1'b0;
      chk("rst_awready", {31'd0, awready_l}, 32'd0);
      chk("rst_wready",  {31'd0, wready_l},  32'd0);
      chk("rst_bvalid",  {31'd0, bvalid_l},  32'd0);
      chk("rst_arready", {31'd0, arready_l}, 32'd0);
      chk("rst_rvalid",  {31'd0, rvalid_l},  32'd0);
      chk("rst_rdata",   rdata_l,            32'd0);
      chk("rst_resp",    {28'd0, bresp_l, rresp_l}, 32'd0);

      // Register access table
      for (int i = 0; i < 12; i++) begin
         axi_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, 1'b0, 4'd0);
         axi_read(tbl[i].raddr, rd, mx);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      end

      // Rising edge on source 0 -> ISR/IPR set, irq within two cycles
      intr_src[0] = 1'b1;
      step(); step();
      chk("edge_irq", {31'd0, irq_l}, 32'd1);
      axi_read(5'h08, rd, mx);
      chk("edge_isr", rd, 32'd1);
      axi_read(5'h10, rd, mx);
      chk("edge_ipr", rd, 32'd1);

      // Acknowledge clears pending and irq
      axi_write(5'h0C, 32'd1, 4'hF, 1'b0, 4'd0);
      chk("ack_irq_low", {31'd0, irq_l}, 32'd0);
      axi_read(5'h10, rd, mx);
      chk("ack_ipr", rd, 32'd0);

      // Ack and fresh edge in the same cycle: status survives
      intr_src[0] = 1'b0; step();
      intr_src[0] = 1'b1; step(); step();
      intr_src[0] = 1'b0; step();
      axi_write(5'h0C, 32'd1, 4'hF, 1'b1, intr_src | 4'b0001);
      chk("ack_edge_irq", {31'd0, irq_l}, 32'd1);
      axi_read(5'h08, rd, mx);
      chk("ack_edge_isr", rd, 32'd1);

      // GIE gating
      axi_write(5'h0C, 32'd1, 4'hF, 1'b0, 4'd0);
      axi_write(5'h00, 32'd0, 4'hF, 1'b0, 4'd0);
      intr_src[0] = 1'b0; step();
      intr_src[0] = 1'b1; step(); step();
      chk("gie0_irq", {31'd0, irq_l}, 32'd0);
      axi_read(5'h10, rd, mx);
      chk("gie0_ipr", rd, 32'd1);
      axi_write(5'h00, 32'd1, 4'hF, 1'b0, 4'd0);
      chk("gie1_irq", {31'd0, irq_l}, 32'd1);

      // Pulse width
      axi_write(5'h0C, 32'd1, 4'hF, 1'b0, 4'd0);
      intr_src[0] = 1'b0; step(); step(); step();
      intr_src[0] = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (irq_p) cnt++;
      end
      chk("pulse_len", 32'(cnt), 32'(PLEN));
      chk("pre_reset_irq", {31'd0, irq_l}, 32'd1);

      // Reset while rvalid is held
      araddr = 5'h08; arvalid = 1'b1; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (arready_l) got = 1;
         step();
      end
      arvalid = 1'b0;
      if (!got) chk("rst_rd_timeout", 32'd0, 32'd1);
      step();
      chk("rvalid_held", {31'd0, rvalid_l}, 32'd1);
      areset = 1'b1;
      step();
      chk("rst_mid_rvalid", {31'd0, rvalid_l}, 32'd0);
      chk("rst_mid_irq_l",  {31'd0, irq_l},    32'd0);
      chk("rst_mid_irq_p",  {31'd0, irq_p},    32'd0);
      areset = 1'b0;
      intr_src = IDLE_SRC;
      step();

      // Randomized traffic against the model
      for (int it = 0; it < 300; it++) begin
         int op;
         if ($urandom_range(0, 2) == 0) intr_src = 4'($urandom);
         op = int'($urandom_range(0, 9));
         if (op == 7 || op == 8) begin
            logic [4:0] a;
            case ($urandom_range(0, 2))
               0:       a = 5'h00;
               1:       a = 5'h04;
               default: a = 5'h0C;
            endcase
            axi_write(a, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 1'b0, 4'd0);
         end else if (op == 9) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 7) * 4);
            axi_read(a, rd, mx);
            chk("rand_rdata", rd, mx);
         end else begin
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
